rv32i_alu_pipe: RTL and testbench

Parametrised, pipelined integer ALU functional unit for the out-of-order backend, and the successor to the single-cycle adder unit. It executes the RV32I register/immediate ALU operations at configurable data width. Latency is a configurable number of elastic pipeline stages. Each result carries its physical-register tag and ROB index to the writeback/CDB arbiter. All stages use valid/ready backpressure, and a flush input squashes in-flight work on mispredict.

---
 rtl/rv32i_pkg.sv | 23 ++
 rtl/rv32i_alu_stage.sv | 36 +++
 rtl/rv32i_alu_pipe.sv | 132 +++++++++++++
 tb/tb_rv32i_alu_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared backend types for the RV32I integer pipeline.
// Holds the ALU opcode enum and the backend tag/ROB sizing constants.
// Imported by rv32i_alu_pipe and rv32i_alu_stage.
package rv32i_pkg;

  localparam int PHYS_REG_FILE_IDX_BW = 6;
  localparam int ROB_DEPTH            = 32;
  localparam int ALU_OP_BW            = 4;

  typedef enum logic [ALU_OP_BW-1:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    SLT  = 4'd2,
    SLTU = 4'd3,
    AND  = 4'd4,
    OR   = 4'd5,
    XOR  = 4'd6,
    SLL  = 4'd7,
    SRL  = 4'd8,
    SRA  = 4'd9
  } alu_op_e;

endpackage

// File: rtl/rv32i_alu_stage.sv
// rv32i_alu_stage: one elastic register slice carrying a W-bit payload.
// Latency: 1 cycle from load to dn_vld.
// Backpressure: loads whenever empty or downstream ready; flush clears valid, keeps payload.
module rv32i_alu_stage
  import rv32i_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  input  logic         up_vld,
  input  logic [W-1:0] up_dat,
  input  logic         dn_rdy,
  output logic         dn_vld,
  output logic [W-1:0] dn_dat
);

  logic ld;

  assign ld = ~dn_vld | dn_rdy;

  // Valid follows upstream on load; payload only captures real ops so bubbles do not disturb it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dn_vld <= 1'b0;
      dn_dat <= '0;
    end else if (flush) begin
      dn_vld <= 1'b0;
    end else if (ld) begin
      dn_vld <= up_vld;
      if (up_vld) dn_dat <= up_dat;
    end
  end

endmodule

// File: rtl/rv32i_alu_pipe.sv
// rv32i_alu_pipe: pipelined RV32I register/immediate ALU with tag and ROB index passthrough.
// Latency: PIPE_STAGES register stages; result visible PIPE_STAGES-1 edges after the accepting edge.
// Backpressure: per-stage valid/ready, bubbles compress, i_flush squashes all in-flight ops.
// Option: define RV32I_ALU_OVERFLOW_EN to compute and carry signed overflow for ADD/SUB.
module rv32i_alu_pipe
  import rv32i_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_BW      = PHYS_REG_FILE_IDX_BW,
  parameter int ROB_IDX_BW  = $clog2(ROB_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_flush,
  input  logic                  i_vld,
  output logic                  o_rdy,
  input  logic [ALU_OP_BW-1:0]  i_op,
  input  logic [XLEN-1:0]       i_a,
  input  logic [XLEN-1:0]       i_b,
  input  logic [TAG_BW-1:0]     i_dst_phys_rf_tag,
  input  logic [ROB_IDX_BW-1:0] i_rob_entry_idx,
  output logic                  o_vld,
  input  logic                  i_rdy,
  output logic [XLEN-1:0]       o_result,
  output logic [TAG_BW-1:0]     o_dst_phys_rf_tag,
  output logic [ROB_IDX_BW-1:0] o_rob_entry_idx,
  output logic                  o_overflow
);

  localparam int SHW = $clog2(XLEN);
`ifdef RV32I_ALU_OVERFLOW_EN
  localparam int SUM_W = XLEN + 1;
`else
  localparam int SUM_W = XLEN;
`endif

  typedef struct packed {
    logic [XLEN-1:0]       result;
`ifdef RV32I_ALU_OVERFLOW_EN
    logic                  ovf;
`endif
    logic [TAG_BW-1:0]     tag;
    logic [ROB_IDX_BW-1:0] rob;
  } pay_t;

  alu_op_e          op;
  logic [SHW-1:0]   shamt;
  logic [SUM_W-1:0] a_ext;
  logic [SUM_W-1:0] b_ext;
  logic [SUM_W-1:0] sum;
  logic [XLEN-1:0]  res;
  pay_t             in_pay;

  logic [PIPE_STAGES:0] vld;
  logic [PIPE_STAGES:0] rdy;
  logic                 all_vld;
  pay_t                 dat [PIPE_STAGES+1];

  assign op = alu_op_e'(i_op);

  // Single-cycle ALU ahead of stage 0; the sum is sign-extended by one bit when overflow is tracked.
  always_comb begin
    shamt = i_b[SHW-1:0];
    a_ext = SUM_W'($signed(i_a));
    b_ext = SUM_W'($signed(i_b));
    sum   = a_ext + ((op == SUB) ? (~b_ext + SUM_W'(1)) : b_ext);
    case (op)
      ADD, SUB: res = sum[XLEN-1:0];
      SLT:      res = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      SLTU:     res = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      AND:      res = i_a & i_b;
      OR:       res = i_a | i_b;
      XOR:      res = i_a ^ i_b;
      SLL:      res = i_a << shamt;
      SRL:      res = i_a >> shamt;
      SRA:      res = $signed(i_a) >>> shamt;
      default:  res = '0;
    endcase
  end

  // Pack the stage-0 payload; overflow only exists for ADD/SUB.
  always_comb begin
    in_pay.result = res;
`ifdef RV32I_ALU_OVERFLOW_EN
    in_pay.ovf    = ((op == ADD) || (op == SUB)) & (sum[XLEN] ^ sum[XLEN-1]);
`endif
    in_pay.tag    = i_dst_phys_rf_tag;
    in_pay.rob    = i_rob_entry_idx;
  end

  assign vld[0] = i_vld;
  assign dat[0] = in_pay;

  // Ready for stage k is high unless every stage from k to the output is full and i_rdy is low.
  always_comb begin
    rdy              = '0;
    all_vld          = 1'b1;
    rdy[PIPE_STAGES] = i_rdy;
    for (int j = PIPE_STAGES - 1; j >= 0; j--) begin
      all_vld = all_vld & vld[j+1];
      rdy[j]  = ~all_vld | i_rdy;
    end
  end

  assign o_rdy = rdy[0];

  genvar k;
  for (k = 0; k < PIPE_STAGES; k++) begin : g_stage
    rv32i_alu_stage #(.W($bits(pay_t))) u_stage (
      .clk    (clk),
      .rstn   (rstn),
      .flush  (i_flush),
      .up_vld (vld[k]),
      .up_dat (dat[k]),
      .dn_rdy (rdy[k+1]),
      .dn_vld (vld[k+1]),
      .dn_dat (dat[k+1])
    );
  end

  assign o_vld             = vld[PIPE_STAGES];
  assign o_result          = dat[PIPE_STAGES].result;
  assign o_dst_phys_rf_tag = dat[PIPE_STAGES].tag;
  assign o_rob_entry_idx   = dat[PIPE_STAGES].rob;
`ifdef RV32I_ALU_OVERFLOW_EN
  assign o_overflow        = dat[PIPE_STAGES].ovf;
`else
  assign o_overflow        = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_alu_pipe.sv
// tb_rv32i_alu_pipe: randomized and directed checks of rv32i_alu_pipe with PIPE_STAGES=2.
// Reference is an arithmetic op model plus an in-order queue of in-flight ops.
// Overflow expectations follow RV32I_ALU_OVERFLOW_EN.
module tb_rv32i_alu_pipe;
  import rv32i_pkg::*;

  localparam int S  = 2;
  localparam int XL = 32;
  localparam int TB = PHYS_REG_FILE_IDX_BW;
  localparam int RB = $clog2(ROB_DEPTH);
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic          clk;
  logic          rstn;
  logic          i_flush;
  logic          i_vld;
  logic          o_rdy;
  logic [3:0]    i_op;
  logic [XL-1:0] i_a;
  logic [XL-1:0] i_b;
  logic [TB-1:0] i_dst_phys_rf_tag;
  logic [RB-1:0] i_rob_entry_idx;
  logic          o_vld;
  logic          i_rdy;
  logic [XL-1:0] o_result;
  logic [TB-1:0] o_dst_phys_rf_tag;
  logic [RB-1:0] o_rob_entry_idx;
  logic          o_overflow;

  rv32i_alu_pipe #(.XLEN(XL), .PIPE_STAGES(S), .TAG_BW(TB), .ROB_IDX_BW(RB)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .i_flush           (i_flush),
    .i_vld             (i_vld),
    .o_rdy             (o_rdy),
    .i_op              (i_op),
    .i_a               (i_a),
    .i_b               (i_b),
    .i_dst_phys_rf_tag (i_dst_phys_rf_tag),
    .i_rob_entry_idx   (i_rob_entry_idx),
    .o_vld             (o_vld),
    .i_rdy             (i_rdy),
    .o_result          (o_result),
    .o_dst_phys_rf_tag (o_dst_phys_rf_tag),
    .o_rob_entry_idx   (o_rob_entry_idx),
    .o_overflow        (o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XL-1:0] res;
    logic          ovf;
    logic [TB-1:0] tag;
    logic [RB-1:0] rob;
    int            t;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_fail;
  int   now;
  int   n_acc;
  logic held;
  logic [XL-1:0] h_res;
  logic [TB-1:0] h_tag;
  logic [RB-1:0] h_rob;
  logic          h_ovf;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, now);
    end
  endtask

  // Behavioural op model: {overflow, result} from two's-complement arithmetic on wide integers.
  function automatic logic [32:0] ref_alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    logic [31:0] r;
    logic v;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b & 32'd31);
    r  = '0;
    v  = 1'b0;
    s  = 0;
    case (op)
      ADD:  begin s = sa + sb; r = a + b; v = (s > MAXS) || (s < MINS); end
      SUB:  begin s = sa - sb; r = a - b; v = (s > MAXS) || (s < MINS); end
      SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      SLTU: r = (a < b) ? 32'd1 : 32'd0;
      AND:  r = a & b;
      OR:   r = a | b;
      XOR:  r = a ^ b;
      SLL:  r = a << sh;
      SRL:  r = a >> sh;
      SRA:  begin s = sa >>> sh; r = s[31:0]; end
      default: r = '0;
    endcase
`ifndef RV32I_ALU_OVERFLOW_EN
    v = 1'b0;
`endif
    return {v, r};
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle: drive, check at negedge against the queue model, then advance.
  task automatic cyc(input logic v, input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                     input logic r, input logic f);
    exp_t e;
    logic [32:0] m;
    logic ev, er;
    i_vld = v; i_op = op; i_a = a; i_b = b; i_rdy = r; i_flush = f;
    i_dst_phys_rf_tag = TB'($urandom);
    i_rob_entry_idx   = RB'($urandom);
    @(negedge clk);
    er = (q.size() < S) || r;
    ev = (q.size() > 0) && (now >= q[0].t + S);
    check("o_rdy", o_rdy, er);
    check("o_vld", o_vld, ev);
    if (held) begin
      check("stall_result", o_result, h_res);
      check("stall_tag", o_dst_phys_rf_tag, h_tag);
      check("stall_rob", o_rob_entry_idx, h_rob);
      check("stall_ovf", o_overflow, h_ovf);
    end
    if (ev && r && !f) begin
      e = q.pop_front();
      check("result", o_result, e.res);
      check("overflow", o_overflow, e.ovf);
      check("tag", o_dst_phys_rf_tag, e.tag);
      check("rob_idx", o_rob_entry_idx, e.rob);
    end
    held  = ev && !r && !f;
    h_res = o_result; h_tag = o_dst_phys_rf_tag; h_rob = o_rob_entry_idx; h_ovf = o_overflow;
    if (f) begin
      q.delete();
    end else if (v && er) begin
      m     = ref_alu(op, a, b);
      e.res = m[31:0];
      e.ovf = m[32];
      e.tag = i_dst_phys_rf_tag;
      e.rob = i_rob_entry_idx;
      e.t   = now;
      q.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic idle(input logic r);
    cyc(1'b0, ADD, 32'h0, 32'h0, r, 1'b0);
  endtask

  task automatic do_reset();
    rstn = 1'b0; i_vld = 1'b0; i_flush = 1'b0; i_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    q.delete();
    held = 1'b0;
    @(negedge clk);
    check("rst_o_vld", o_vld, 1'b0);
    check("rst_o_result", o_result, 32'h0);
    check("rst_o_overflow", o_overflow, 1'b0);
    check("rst_o_tag", o_dst_phys_rf_tag, '0);
    check("rst_o_rob", o_rob_entry_idx, '0);
    check("rst_o_rdy", o_rdy, 1'b1);
    @(posedge clk);
    #1;
    now++;
  endtask

  initial begin
    logic [3:0] pat;
    logic       f;
    clk = 1'b0; rstn = 1'b0; i_flush = 1'b0; i_vld = 1'b0; i_rdy = 1'b1;
    i_op = '0; i_a = '0; i_b = '0; i_dst_phys_rf_tag = '0; i_rob_entry_idx = '0;
    n_chk = 0; n_fail = 0; now = 0; n_acc = 0; held = 1'b0;
    h_res = '0; h_tag = '0; h_rob = '0; h_ovf = 1'b0;

    do_reset();

    // Corner ops, back-to-back with no stall.
    cyc(1'b1, ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    repeat (3) idle(1'b1);
    cyc(1'b1, SUB,  32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0);
    cyc(1'b1, SLT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    cyc(1'b1, SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    cyc(1'b1, SRA,  32'h8000_0000, 32'h0000_0021, 1'b1, 1'b0);
    cyc(1'b1, SLL,  32'h0000_0001, 32'd31,        1'b1, 1'b0);
    repeat (4) idle(1'b1);

    // Eight ops with i_rdy toggling 1,0,0,1.
    pat   = 4'b1001;
    n_acc = 0;
    for (int i = 0; i < 64 && !(n_acc == 8 && q.size() == 0); i++)
      cyc(n_acc < 8, alu_op_e'($urandom_range(0, 9)), rnd_opnd(), rnd_opnd(), pat[i % 4], 1'b0);
    repeat (2) idle(1'b1);

    // Fill, flush with an input present, then a normal op.
    repeat (3) cyc(1'b1, alu_op_e'($urandom_range(0, 9)), rnd_opnd(), rnd_opnd(), 1'b0, 1'b0);
    cyc(1'b1, ADD, 32'h1234_5678, 32'h1, 1'b0, 1'b1);
    repeat (3) idle(1'b1);
    cyc(1'b1, XOR, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 1'b1, 1'b0);
    repeat (3) idle(1'b1);

    // Reset mid-stream.
    repeat (3) cyc(1'b1, alu_op_e'($urandom_range(0, 9)), rnd_opnd(), rnd_opnd(), 1'b0, 1'b0);
    do_reset();
    repeat (3) idle(1'b1);

    // Random traffic with occasional flushes.
    repeat (400) begin
      f = ($urandom_range(0, 24) == 0);
      cyc($urandom_range(0, 3) != 0, alu_op_e'($urandom_range(0, 9)), rnd_opnd(), rnd_opnd(),
          f ? 1'b0 : ($urandom_range(0, 2) != 0), f);
    end
    repeat (6) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
